// File: rtl/ram16_8bit_loader.sv
// ram16_8bit_loader
//
// Write-side loader for the 16x8 program RAM. It takes a byte stream over a
// valid/ready handshake and writes each byte into the external RAM. Every byte
// uses a three-cycle sequence:
//   RECV  : wait for a byte; in_ready is high.
//   WRITE : low_we is low for one cycle; address and data are stable.
//   HOLD  : low_we is high again; address and data are held for RAM hold time.
// The block writes addresses START_ADDR..DEPTH-1 and then reports completion.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready is registered and is high only in RECV (and in CSUM when the
// checksum feature is built in). The source may hold in_valid at any time.
// While in_ready is low, in_data is not consumed.
//
// Optional feature: define LOADER_CSUM_EN to add a trailing checksum byte.
// When it is enabled, an 8-bit running sum covers every written byte. After the
// last word, one extra byte is accepted but not written to RAM. csum_err
// reports whether the sum plus that byte is non-zero mod 256. When the macro is
// undefined, csum_err is tied low.
//
// Ports:
//   clk       in   clock; all state changes on the rising edge
//   clr       in   synchronous active-high reset; overrides every other input
//   start     in   one-cycle pulse that starts a load (only from IDLE/DONE)
//   in_data   in   [DATA_W-1:0] stream byte
//   in_valid  in   in_data is valid
//   in_ready  out  loader accepts a byte this cycle
//   mem_addr  out  [ADDR_W-1:0] RAM address
//   mem_data  out  [DATA_W-1:0] RAM write data
//   low_we    out  active-low RAM write strobe
//   busy      out  load in progress
//   done      out  load complete; held until the next start or clr
//   csum_err  out  checksum mismatch (tied low without LOADER_CSUM_EN)

module ram16_8bit_loader #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              low_we,
    output logic              busy,
    output logic              done,
    output logic              csum_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4,
        S_CSUM  = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              we_n_d;
    logic              ready_d;
    logic              busy_d;
    logic              done_d;

    logic accept;
    logic at_last;

    assign accept  = in_valid && in_ready;
    assign at_last = (mem_addr == LAST_ADDR);

`ifdef LOADER_CSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;
    logic              csum_err_q;
    logic              csum_err_d;

    assign csum_err = csum_err_q;
`else
    assign csum_err = 1'b0;
`endif

    // State and output registers. Every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            mem_addr <= '0;
            mem_data <= '0;
            low_we   <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef LOADER_CSUM_EN
            sum_q      <= '0;
            csum_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mem_addr <= addr_d;
            mem_data <= data_d;
            low_we   <= we_n_d;
            in_ready <= ready_d;
            busy     <= busy_d;
            done     <= done_d;
`ifdef LOADER_CSUM_EN
            sum_q      <= sum_d;
            csum_err_q <= csum_err_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_RECV;
            end
            S_RECV: begin
                if (accept) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (at_last) begin
`ifdef LOADER_CSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_RECV;
                end
            end
            S_CSUM: begin
                if (accept) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic. This block computes the values the output flops load on
    // the next edge. The strobe and ready follow the state being entered, so
    // they line up with that state.
    always_comb begin
        addr_d  = mem_addr;
        data_d  = mem_data;
        busy_d  = busy;
        done_d  = done;
        we_n_d  = (state_d != S_WRITE);
        ready_d = (state_d == S_RECV) || (state_d == S_CSUM);
`ifdef LOADER_CSUM_EN
        sum_d      = sum_q;
        csum_err_d = csum_err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_d = FIRST_ADDR;
                    busy_d = 1'b1;
                    done_d = 1'b0;
`ifdef LOADER_CSUM_EN
                    sum_d      = '0;
                    csum_err_d = 1'b0;
`endif
                end
            end
            S_RECV: begin
                if (accept) begin
                    data_d = in_data;
`ifdef LOADER_CSUM_EN
                    sum_d = sum_q + in_data;
`endif
                end
            end
            S_HOLD: begin
                // The counter stops at the last word and never wraps.
                if (!at_last) begin
                    addr_d = mem_addr + ADDR_W'(1);
                end else begin
`ifndef LOADER_CSUM_EN
                    busy_d = 1'b0;
                    done_d = 1'b1;
`endif
                end
            end
            S_CSUM: begin
                // The checksum byte only updates the status. It is never written.
                if (accept) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
`ifdef LOADER_CSUM_EN
                    csum_err_d = ((sum_q + in_data) != '0);
`endif
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram16_8bit_loader.sv
module tb_ram16_8bit_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       low_we;
  logic       busy;
  logic       done;
  logic       csum_err;

  // second instance, START_ADDR = 12, separate stimulus
  logic       p_start = 1'b0;
  logic [7:0] p_in_data = 8'h00;
  logic       p_in_valid = 1'b0;
  logic       p_in_ready;
  logic [3:0] p_mem_addr;
  logic [7:0] p_mem_data;
  logic       p_low_we;
  logic       p_busy;
  logic       p_done;
  logic       p_csum_err;

  ram16_8bit_loader dut (
    .clk(clk), .clr(clr), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .low_we(low_we),
    .busy(busy), .done(done), .csum_err(csum_err)
  );

  ram16_8bit_loader #(.START_ADDR(12)) dut_p (
    .clk(clk), .clr(clr), .start(p_start), .in_data(p_in_data), .in_valid(p_in_valid),
    .in_ready(p_in_ready), .mem_addr(p_mem_addr), .mem_data(p_mem_data), .low_we(p_low_we),
    .busy(p_busy), .done(p_done), .csum_err(p_csum_err)
  );

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  logic [11:0] wr_q[$];
  logic [11:0] p_wr_q[$];

  // write monitors: one entry per cycle the strobe is low
  always @(negedge clk) begin
    if (!low_we) wr_q.push_back({mem_addr, mem_data});
    if (!p_low_we) p_wr_q.push_back({p_mem_addr, p_mem_data});
  end

  // ---------------- driver ----------------
  logic [7:0] s_first;
  logic [7:0] s_tail;
  int s_n;
  int s_gap;
  int s_idx;
  int s_gap_left;
  int s_cycles;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load(input logic [7:0] first, input int n, input int gap,
                            input logic [7:0] tail);
    s_first = first;
    s_n = n;
    s_gap = gap;
    s_tail = tail;
    s_idx = 0;
    s_gap_left = 0;
    s_cycles = 0;
    wr_q.delete();
    exp_q.delete();
    start = 1'b1;
    in_valid = 1'b1;
    in_data = first;
    tick();
    start = 1'b0;
  endtask

  // one clock of the stream source; bytes beyond 16 use the tail value
  task automatic step();
    logic acc;
    acc = in_valid && in_ready;
    tick();
    s_cycles++;
    if (acc) begin
      s_idx++;
      s_gap_left = s_gap;
    end
    if (s_idx < s_n && s_gap_left == 0) begin
      in_valid = 1'b1;
      in_data = (s_idx < 16) ? s_first + 8'(s_idx) : s_tail;
    end else begin
      in_valid = 1'b0;
      if (s_gap_left > 0) s_gap_left--;
    end
  endtask

  task automatic run_until_done(input int budget);
    while (!done && s_cycles < budget) step();
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom_range(0, 255));
      tick();
    end
    n_vec++; if (low_we !== 1'b1) begin n_err++; $display("FAIL reset_low_we got %b want 1", low_we); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (mem_addr !== 4'h0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_vec++; if (mem_data !== 8'h00) begin n_err++; $display("FAIL reset_mem_data got %h want 00", mem_data); end
    n_vec++; if (csum_err !== 1'b0) begin n_err++; $display("FAIL reset_csum_err got %b want 0", csum_err); end
    n_vec++; if (p_mem_addr !== 4'h0) begin n_err++; $display("FAIL reset_p_mem_addr got %h want 0", p_mem_addr); end
    clr = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    tick();
  endtask

  task automatic check_writes(input string name);
    n_vec++;
    if (wr_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s_write_count got %0d want %0d", name, wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (wr_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL %s_write[%0d] got addr/data %h want %h", name, i, wr_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_full_load();
    begin_load(8'h00, 16, 0, 8'h00);
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'(i)});
    run_until_done(200);
    n_vec++; if (s_cycles != 48 || done !== 1'b1) begin n_err++; $display("FAIL full_latency got %0d cycles done=%b want 48 done=1", s_cycles, done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy got %b want 0", busy); end
    n_vec++; if (low_we !== 1'b1) begin n_err++; $display("FAIL full_low_we got %b want 1", low_we); end
    n_vec++; if (csum_err !== 1'b0) begin n_err++; $display("FAIL full_csum_err got %b want 0", csum_err); end
    tick();
    check_writes("full");
    // done holds after completion
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL full_done_hold got %b want 1", done); end
  endtask

  task automatic test_backpressure();
    begin_load(8'h30, 16, 5, 8'h00);
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'h30 + 8'(i)});
    while (!done && s_cycles < 400) begin
      step();
      // waiting in RECV with no byte offered: address must be the next slot
      if (in_ready && !in_valid) begin
        n_vec++;
        if (mem_addr !== 4'(s_idx)) begin
          n_err++;
          $display("FAIL gap_addr_stable got %h want %h", mem_addr, 4'(s_idx));
        end
      end
    end
    in_valid = 1'b0;
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL gap_done got %b want 1", done); end
    tick();
    check_writes("gap");
  endtask

  task automatic test_abort_restart();
    begin_load(8'h40, 16, 0, 8'h00);
    for (int i = 0; i < 5; i++) exp_q.push_back({4'(i), 8'h40 + 8'(i)});
    while (s_idx < 3 && s_cycles < 100) step();
    start = 1'b1;
    step();
    start = 1'b0;
    while (s_idx < 5 && s_cycles < 100) step();
    clr = 1'b1;
    in_valid = 1'b0;
    tick();
    clr = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    n_vec++; if (low_we !== 1'b1) begin n_err++; $display("FAIL abort_low_we got %b want 1", low_we); end
    n_vec++; if (mem_addr !== 4'h0) begin n_err++; $display("FAIL abort_mem_addr got %h want 0", mem_addr); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL abort_in_ready got %b want 0", in_ready); end
    tick();
    check_writes("abort");

    begin_load(8'h60, 16, 0, 8'h00);
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'h60 + 8'(i)});
    run_until_done(200);
    n_vec++; if (s_cycles != 48 || done !== 1'b1) begin n_err++; $display("FAIL restart_latency got %0d cycles done=%b want 48 done=1", s_cycles, done); end
    tick();
    check_writes("restart");
  endtask

  task automatic test_partial();
    int idx;
    int cyc;
    logic acc;
    p_wr_q.delete();
    p_start = 1'b1;
    p_in_valid = 1'b1;
    p_in_data = 8'hA0;
    tick();
    p_start = 1'b0;
    idx = 0;
    cyc = 0;
    while (!p_done && cyc < 100) begin
      acc = p_in_valid && p_in_ready;
      tick();
      cyc++;
      if (acc) idx++;
      p_in_data = 8'hA0 + 8'(idx);
    end
    p_in_valid = 1'b0;
    n_vec++; if (cyc != 12 || p_done !== 1'b1) begin n_err++; $display("FAIL partial_latency got %0d cycles done=%b want 12 done=1", cyc, p_done); end
    n_vec++; if (p_busy !== 1'b0) begin n_err++; $display("FAIL partial_busy got %b want 0", p_busy); end
    tick();
    n_vec++;
    if (p_wr_q.size() != 4) begin
      n_err++;
      $display("FAIL partial_write_count got %0d want 4", p_wr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (p_wr_q[i] !== {4'(12 + i), 8'hA0 + 8'(i)}) begin
          n_err++;
          $display("FAIL partial_write[%0d] got %h want %h", i, p_wr_q[i], {4'(12 + i), 8'hA0 + 8'(i)});
        end
      end
    end
  endtask

`ifdef LOADER_CSUM_EN
  task automatic test_csum(input logic [7:0] tail, input logic want_err, input string name);
    begin_load(8'h01, 17, 0, tail);
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'h01 + 8'(i)});
    run_until_done(200);
    n_vec++; if (s_cycles != 49 || done !== 1'b1) begin n_err++; $display("FAIL %s_latency got %0d cycles done=%b want 49 done=1", name, s_cycles, done); end
    n_vec++; if (csum_err !== want_err) begin n_err++; $display("FAIL %s_csum_err got %b want %b", name, csum_err, want_err); end
    tick();
    check_writes(name);
  endtask
`endif

  // ---------------- main ----------------
  initial begin
    tick();
    test_reset();
    test_full_load();
    test_backpressure();
    test_abort_restart();
    test_partial();
`ifdef LOADER_CSUM_EN
    test_csum(8'h78, 1'b0, "csum_ok");
    test_csum(8'h79, 1'b1, "csum_bad");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram16_8bit_loader.md
Name: ram16_8bit_loader

Overview:
- Write-side counterpart of the program ROM. Accepts a byte stream over a valid/ready handshake and writes it into the 16x8 program RAM through an address/data bus with an active-low write strobe.
- Used in programming mode, before the CPU is released from halt, to load program and data bytes.
- The RAM itself is external; this block owns the address counter, write sequencing and completion status.

Parameters:
- DEPTH, 16, number of memory words; last address written is DEPTH-1.
- ADDR_W, 4, width of mem_addr; DEPTH <= 2**ADDR_W.
- DATA_W, 8, width of the stream and memory word.
- START_ADDR, 0, first address written; legal range 0..DEPTH-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- clr  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; ignored unless the state is IDLE or DONE.
- in_data  input  DATA_W  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_addr  output  ADDR_W  RAM address.
- mem_data  output  DATA_W  RAM write data.
- low_we  output  1  active-low RAM write strobe.
- busy  output  1  load in progress.
- done  output  1  load completed; held until the next start or clr.
- csum_err  output  1  checksum mismatch (see Optional Feature).

Behaviour:
- Reset (clr high at an edge): state=IDLE, mem_addr=0, mem_data=0, low_we=1, in_ready=0, busy=0, done=0, csum_err=0. clr takes priority over every other input.
- All outputs are registered.
- States: IDLE, RECV, WRITE, HOLD, DONE. With the optional feature there is also CSUM.
- IDLE/DONE:
  - start=1 -> RECV; mem_addr=START_ADDR; done=0; busy=1; csum_err=0.
  - Otherwise all outputs hold.
- RECV:
  - in_ready=1.
  - The byte transfers when in_valid && in_ready at an edge. That edge sets mem_data=in_data and moves to WRITE with in_ready=0.
  - While in_valid=0, stay in RECV; low_we stays 1 and mem_addr is stable.
- WRITE:
  - low_we=0 for exactly one cycle; mem_addr and mem_data stable.
  - Next state is HOLD.
- HOLD:
  - low_we=1; addr and data held one more cycle for RAM hold time.
  - If mem_addr==DEPTH-1: go to DONE, or to CSUM when the feature is enabled.
  - Otherwise mem_addr+1 and return to RECV.
- Completion: entering DONE sets busy=0 and done=1.
- Throughput: 3 cycles per byte minimum (RECV accept, WRITE, HOLD). A full 16-byte load with in_valid held high completes in 48 cycles after start.
- Word count: exactly DEPTH-START_ADDR words are written.
  - mem_addr never wraps past DEPTH-1.
  - Unused upper addresses (when DEPTH < 2**ADDR_W) are never driven.
- start while busy: ignored, no effect on the counter.
- in_valid outside RECV: ignored; in_ready=0 there, so no byte is consumed.
- clr mid-load: the next edge returns to the reset state. Words already written stay in RAM. A write strobe in progress ends (low_we=1) at that edge.

Optional Feature:
- Macro: LOADER_CSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) accumulates every accepted data byte.
  - After the last HOLD, the state goes to CSUM with in_ready=1 and accepts one extra byte. That byte is not written to RAM.
  - On acceptance: csum_err = ((sum + byte) mod 256 != 0). Then go to DONE.
  - csum_err holds until the next start or clr.
- Undefined:
  - No CSUM state and no accumulator.
  - csum_err is tied to 0; the port stays present.

Test Plan:
- Reset: assert clr 2 cycles with random inputs -> low_we=1, in_ready=0, busy=0, done=0, mem_addr=0, csum_err=0.
- Full load: start, then bytes 0x00..0x0F with in_valid held high -> 16 single-cycle low_we pulses, each with mem_addr=i and mem_data=i; done=1, busy=0 exactly 48 cycles after start.
- Backpressure gaps: drop in_valid for 5 cycles between every byte -> no extra strobes, mem_addr stable during gaps, every byte written once, total 16 writes.
- Abort and restart:
  - Pulse start again after 3 bytes -> no effect.
  - Assert clr after 5 bytes -> next edge busy=0, low_we=1, mem_addr=0.
  - A new start -> writes begin again at address 0.
- Partial range: START_ADDR=12, bytes 0xA0..0xA3 -> exactly 4 writes to addresses 12..15, then done=1.
- LOADER_CSUM_EN:
  - Bytes 0x01..0x10 (sum 0x88), then checksum 0x78 -> csum_err=0, done=1.
  - Repeat with checksum 0x79 -> csum_err=1.
  - Checksum byte never strobes low_we.
